// File: rtl/soc_bus_arb.sv
// Two-master round-robin arbiter in front of a single CSR slave.
// One transaction is outstanding at a time; a stalled slave is cut off after TIMEOUT cycles.
module soc_bus_arb #(
    parameter int AW      = 11,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_vld,
    input  logic [3:0]    m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdat,
    output logic          m0_rdy,
    output logic [31:0]   m0_rdat,
    input  logic          m1_vld,
    input  logic [3:0]    m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdat,
    output logic          m1_rdy,
    output logic [31:0]   m1_rdat,
    output logic          s_vld,
    output logic [3:0]    s_we,
    output logic [AW-1:0] s_addr,
    output logic [31:0]   s_wdat,
    input  logic          s_rdy,
    input  logic [31:0]   s_rdat,
    output logic          to_err,
    input  logic          to_clr
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          last_gnt_q, last_gnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          s_vld_q, s_vld_d;
    logic [3:0]    s_we_q, s_we_d;
    logic [AW-1:0] s_addr_q, s_addr_d;
    logic [31:0]   s_wdat_q, s_wdat_d;
    logic [31:0]   rdat_q, rdat_d;
    logic          to_err_q, to_err_d;
    logic          winner;
    logic          set_err;

    // On a tie the master that did not win last time gets the bus.
    always_comb begin
        if (m0_vld && m1_vld) begin
            winner = ~last_gnt_q;
        end else begin
            winner = m1_vld;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        cnt_d      = cnt_q;
        s_vld_d    = s_vld_q;
        s_we_d     = s_we_q;
        s_addr_d   = s_addr_q;
        s_wdat_d   = s_wdat_q;
        rdat_d     = rdat_q;
        set_err    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (m0_vld || m1_vld) begin
                    gnt_d    = winner;
                    s_we_d   = winner ? m1_we   : m0_we;
                    s_addr_d = winner ? m1_addr : m0_addr;
                    s_wdat_d = winner ? m1_wdat : m0_wdat;
                    s_vld_d  = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                // A slave answer on the final allowed cycle still counts as a normal completion.
                if (s_rdy) begin
                    rdat_d  = (s_we_q == 4'h0) ? s_rdat : 32'h0;
                    s_vld_d = 1'b0;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdat_d  = 32'hDEAD_BEEF;
                    set_err = 1'b1;
                    s_vld_d = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                last_gnt_d = gnt_q;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (set_err) begin
            to_err_d = 1'b1;
        end else if (to_clr) begin
            to_err_d = 1'b0;
        end else begin
            to_err_d = to_err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            cnt_q      <= '0;
            s_vld_q    <= 1'b0;
            s_we_q     <= 4'h0;
            s_addr_q   <= '0;
            s_wdat_q   <= 32'h0;
            rdat_q     <= 32'h0;
            to_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
            s_vld_q    <= s_vld_d;
            s_we_q     <= s_we_d;
            s_addr_q   <= s_addr_d;
            s_wdat_q   <= s_wdat_d;
            rdat_q     <= rdat_d;
            to_err_q   <= to_err_d;
        end
    end

    // The completion pulse lives exactly in DONE; the other master sees zeros.
    assign m0_rdy  = (state_q == ST_DONE) && !gnt_q;
    assign m1_rdy  = (state_q == ST_DONE) &&  gnt_q;
    assign m0_rdat = m0_rdy ? rdat_q : 32'h0;
    assign m1_rdat = m1_rdy ? rdat_q : 32'h0;

    assign s_vld  = s_vld_q;
    assign s_we   = s_we_q;
    assign s_addr = s_addr_q;
    assign s_wdat = s_wdat_q;
    assign to_err = to_err_q;

endmodule
